// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared NoC definitions used by the router output-port allocators.
//   FLIT_W       : default flit width; the flit type lives in the top two bits
//   flit_type_e  : FLIT_HEAD / FLIT_BODY / FLIT_SINGLE / FLIT_TAIL encodings
//   state_e      : allocator output-port state (ST_IDLE, ST_LOCKED)
//   is_head_type : true for flit types that may open a new packet
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int FLIT_W = 32;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_SINGLE = 2'b10,
    FLIT_TAIL   = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Head and single-flit packets are the only flits allowed to win arbitration.
  function automatic logic is_head_type(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

endpackage : noc_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Grants the first requester found
// searching upward from ptr, wrapping past N-1 back to 0.
//   req : N-bit request vector
//   ptr : index of the highest-priority requester (must be < N)
//   gnt : one-hot grant, zero when req is zero
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic w_found;

  // For each priority offset i, exactly one index j equals (ptr + i) mod N;
  // the outer loop walks priority order, the inner loop is a constant-index
  // compare so no variable bit-select is needed.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it holding its old value and infer a latch.
    gnt     = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && req[j] && (((int'(ptr) + i) % N) == j)) begin
          gnt[j]  = 1'b1;
          w_found = 1'b1;
        end
      end
    end
  end

endmodule : rr_pick

// File: rtl/sw_alloc_rr.sv
// -----------------------------------------------------------------------------
// sw_alloc_rr
// N_IN-to-1 wormhole switch allocator for one router output port. Round-robin
// arbitration among head/single flits; a head locks the output to its input
// until the matching tail. Flits pass combinationally to the downstream link,
// paced by a credit counter that tracks free downstream buffer slots.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid_i    : per-input flit valid
//   in_data_i     : packed flits, input k at [k*FLIT_W +: FLIT_W]
//   in_ready_o    : per-input accept (transfer on valid & ready)
//   out_valid_o   : flit presented downstream, consumes one credit
//   out_data_o    : selected flit, zero when out_valid_o is low
//   credit_ret_i  : downstream freed one buffer slot (pulse)
//   grant_o       : one-hot current owner / arbitration winner
//   locked_o      : a multi-flit packet owns the output
//   err_o         : sticky [0] protocol error, [1] credit overflow
// -----------------------------------------------------------------------------
module sw_alloc_rr
  import noc_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int FLIT_W  = noc_pkg::FLIT_W,
  parameter int CREDITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN-1:0]        in_valid_i,
  input  logic [N_IN*FLIT_W-1:0] in_data_i,
  output logic [N_IN-1:0]        in_ready_o,
  output logic                   out_valid_o,
  output logic [FLIT_W-1:0]      out_data_o,
  input  logic                   credit_ret_i,
  output logic [N_IN-1:0]        grant_o,
  output logic                   locked_o,
  output logic [1:0]             err_o
);

  localparam int PTR_W = $clog2(N_IN);
  localparam int CNT_W = $clog2(CREDITS + 1);

  // State
  state_e             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_credit_cnt;
  logic [1:0]         r_err;

  // Per-input decode
  flit_type_e         w_type [N_IN];
  logic [N_IN-1:0]    w_elig;
  logic [N_IN-1:0]    w_rr_gnt;
  logic [N_IN-1:0]    w_drop_sel;
  logic [N_IN-1:0]    w_owner_oh;
  logic               w_drop_found;

  // Selected path
  logic               w_credit_ok;
  logic               w_xfer;
  logic               w_drop;
  logic [PTR_W-1:0]   w_sel_idx;
  logic [FLIT_W-1:0]  w_sel_flit;
  flit_type_e         w_sel_type;

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    assign w_type[k] = flit_type_e'(in_data_i[k*FLIT_W + FLIT_W - 2 +: 2]);
    assign w_elig[k] = in_valid_i[k] & is_head_type(w_type[k]);
  end

  rr_pick #(
    .N     (N_IN),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (w_elig),
    .ptr (r_rr_ptr),
    .gnt (w_rr_gnt)
  );

  // Lowest-index valid input; only used when nothing is eligible, in which
  // case that input necessarily carries a stray body or tail flit.
  always_comb begin
    w_drop_sel   = '0;
    w_drop_found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (!w_drop_found && in_valid_i[k]) begin
        w_drop_sel[k] = 1'b1;
        w_drop_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_owner_oh = '0;
    for (int k = 0; k < N_IN; k++) begin
      w_owner_oh[k] = (k == int'(r_owner));
    end
  end

  assign w_credit_ok = (r_credit_cnt != '0);

  // Grant, handshake and discard decisions.
  always_comb begin
    grant_o     = '0;
    in_ready_o  = '0;
    out_valid_o = 1'b0;
    w_drop      = 1'b0;
    if (r_state == ST_IDLE) begin
      grant_o     = w_rr_gnt;
      out_valid_o = (|w_rr_gnt) & w_credit_ok;
      if (out_valid_o) begin
        in_ready_o = w_rr_gnt;
      end else if (!(|w_elig) && (|in_valid_i) && w_credit_ok) begin
        // Stray body/tail with no packet open: swallow it so it cannot
        // block the input forever. A zero credit count still stalls it.
        in_ready_o = w_drop_sel;
        w_drop     = 1'b1;
      end
    end else begin
      grant_o     = w_owner_oh;
      out_valid_o = (|(in_valid_i & w_owner_oh)) & w_credit_ok;
      in_ready_o  = w_owner_oh & {N_IN{w_credit_ok}};
    end
  end

  assign w_xfer = out_valid_o;

  // Index of the input currently driving the output.
  always_comb begin
    w_sel_idx = r_owner;
    if (r_state == ST_IDLE) begin
      w_sel_idx = '0;
      for (int k = 0; k < N_IN; k++) begin
        if (w_rr_gnt[k]) w_sel_idx = PTR_W'(k);
      end
    end
  end

  always_comb begin
    w_sel_flit = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (k == int'(w_sel_idx)) w_sel_flit = in_data_i[k*FLIT_W +: FLIT_W];
    end
  end

  assign w_sel_type = flit_type_e'(w_sel_flit[FLIT_W-1 -: 2]);
  assign out_data_o = out_valid_o ? w_sel_flit : '0;
  assign locked_o   = (r_state == ST_LOCKED);
  assign err_o      = r_err;

  // NOTE: all state uses non-blocking assignments so every decision below
  // reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_credit_cnt <= CNT_W'(CREDITS);
      r_err        <= '0;
    end else begin
      // A send and a return in the same cycle cancel out.
      if (w_xfer && !credit_ret_i) begin
        r_credit_cnt <= r_credit_cnt - 1'b1;
      end else if (credit_ret_i && !w_xfer) begin
        if (r_credit_cnt == CNT_W'(CREDITS)) r_err[1] <= 1'b1;
        else                                 r_credit_cnt <= r_credit_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_rr_ptr <= (w_sel_idx == PTR_W'(N_IN - 1)) ? '0 : w_sel_idx + 1'b1;
            if (w_sel_type == FLIT_HEAD) begin
              r_state <= ST_LOCKED;
              r_owner <= w_sel_idx;
            end
          end
          if (w_drop) r_err[0] <= 1'b1;
        end
        ST_LOCKED: begin
          // Pointer already advanced at the head; the tail only unlocks.
          if (w_xfer) begin
            if (w_sel_type == FLIT_TAIL)      r_state  <= ST_IDLE;
            else if (is_head_type(w_sel_type)) r_err[0] <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule : sw_alloc_rr

// File: tb/tb_sw_alloc_rr.sv
module tb_sw_alloc_rr;

  localparam int N_IN    = 3;
  localparam int FLIT_W  = 32;
  localparam int CREDITS = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_IN-1:0]        in_valid_i = '0;
  logic [N_IN*FLIT_W-1:0] in_data_i = '0;
  logic [N_IN-1:0]        in_ready_o;
  logic                   out_valid_o;
  logic [FLIT_W-1:0]      out_data_o;
  logic                   credit_ret_i = 1'b0;
  logic [N_IN-1:0]        grant_o;
  logic                   locked_o;
  logic [1:0]             err_o;

  int checks   = 0;
  int failures = 0;

  sw_alloc_rr #(
    .N_IN    (N_IN),
    .FLIT_W  (FLIT_W),
    .CREDITS (CREDITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .credit_ret_i (credit_ret_i),
    .grant_o      (grant_o),
    .locked_o     (locked_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic drive(input logic [2:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic ret);
    in_valid_i   = v;
    in_data_i    = {d2, d1, d0};
    credit_ret_i = ret;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", grant_o); end
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    checks++; if (in_ready_o !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", in_ready_o); end
    checks++; if (out_data_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data_o); end
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked_o); end
    checks++; if (err_o !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", err_o); end
    checks++; if (int'(dut.r_credit_cnt) != 4) begin failures++; $display("FAIL reset_credit got=%0d exp=4", dut.r_credit_cnt); end
  endtask

  task automatic test_rr_single();
    logic [2:0]  gtab [5];
    logic        vtab [5];
    int          ctab [5];
    logic [31:0] exp_d;
    gtab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    vtab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ctab = '{4, 3, 2, 1, 0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(3'b111, 32'h8000_0000, 32'h8000_0001, 32'h8000_0002, 1'b0);
      #2;
      exp_d = 32'h0;
      if (vtab[c]) exp_d = 32'h8000_0000 | ((gtab[c] == 3'b001) ? 0 : (gtab[c] == 3'b010) ? 1 : 2);
      checks++; if (grant_o !== gtab[c]) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, grant_o, gtab[c]); end
      checks++; if (out_valid_o !== vtab[c]) begin failures++; $display("FAIL rr_valid cyc=%0d got=%b exp=%b", c, out_valid_o, vtab[c]); end
      checks++; if (in_ready_o !== (vtab[c] ? gtab[c] : 3'b000)) begin failures++; $display("FAIL rr_ready cyc=%0d got=%b", c, in_ready_o); end
      checks++; if (out_data_o !== exp_d) begin failures++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", c, out_data_o, exp_d); end
      checks++; if (int'(dut.r_credit_cnt) != ctab[c]) begin failures++; $display("FAIL rr_credit cyc=%0d got=%0d exp=%0d", c, dut.r_credit_cnt, ctab[c]); end
    end
  endtask

  task automatic test_wormhole();
    do_reset();
    // Single from input 0 moves the pointer to 1.
    @(negedge clk); drive(3'b001, 32'h8000_00AA, 32'h0, 32'h0, 1'b1); #2;
    checks++; if (grant_o !== 3'b001) begin failures++; $display("FAIL wh_pre_grant got=%b exp=001", grant_o); end
    // Head from input 1 wins over input 0.
    @(negedge clk); drive(3'b011, 32'h0000_0100, 32'h0000_0011, 32'h0, 1'b1); #2;
    checks++; if (grant_o !== 3'b010) begin failures++; $display("FAIL wh_head_grant got=%b exp=010", grant_o); end
    checks++; if (in_ready_o !== 3'b010) begin failures++; $display("FAIL wh_head_ready got=%b exp=010", in_ready_o); end
    checks++; if (out_data_o !== 32'h0000_0011) begin failures++; $display("FAIL wh_head_data got=%h exp=00000011", out_data_o); end
    // Body and tail, input 0 still waiting.
    @(negedge clk); drive(3'b011, 32'h0000_0100, 32'h4000_0012, 32'h0, 1'b1); #2;
    checks++; if (int'(dut.r_rr_ptr) != 2) begin failures++; $display("FAIL wh_ptr got=%0d exp=2", dut.r_rr_ptr); end
    checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL wh_body_locked got=%b exp=1", locked_o); end
    checks++; if (in_ready_o !== 3'b010) begin failures++; $display("FAIL wh_body_ready got=%b exp=010", in_ready_o); end
    checks++; if (out_data_o !== 32'h4000_0012) begin failures++; $display("FAIL wh_body_data got=%h exp=40000012", out_data_o); end
    @(negedge clk); drive(3'b011, 32'h0000_0100, 32'hC000_0013, 32'h0, 1'b1); #2;
    checks++; if (grant_o !== 3'b010) begin failures++; $display("FAIL wh_tail_grant got=%b exp=010", grant_o); end
    checks++; if (in_ready_o !== 3'b010) begin failures++; $display("FAIL wh_tail_ready got=%b exp=010", in_ready_o); end
    checks++; if (out_data_o !== 32'hC000_0013) begin failures++; $display("FAIL wh_tail_data got=%h exp=c0000013", out_data_o); end
    // Input 0 granted the cycle after the tail.
    @(negedge clk); drive(3'b001, 32'h0000_0100, 32'h0, 32'h0, 1'b1); #2;
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL wh_after_locked got=%b exp=0", locked_o); end
    checks++; if (grant_o !== 3'b001) begin failures++; $display("FAIL wh_after_grant got=%b exp=001", grant_o); end
    checks++; if (out_data_o !== 32'h0000_0100) begin failures++; $display("FAIL wh_after_data got=%h exp=00000100", out_data_o); end
  endtask

  task automatic test_credit_stall();
    logic [31:0] flits [6];
    int          ptab  [8];
    logic        rtab  [8];
    logic        vtab  [8];
    logic        ltab  [8];
    int          ctab  [8];
    flits = '{32'h0000_0A00, 32'h4000_0A01, 32'h4000_0A02, 32'h4000_0A03, 32'h4000_0A04, 32'hC000_0A05};
    ptab  = '{0, 1, 2, 3, 4, 4, 4, 5};
    rtab  = '{0, 0, 0, 0, 0, 1, 0, 0};
    vtab  = '{1, 1, 1, 1, 0, 0, 1, 0};
    ltab  = '{0, 1, 1, 1, 1, 1, 1, 1};
    ctab  = '{4, 3, 2, 1, 0, 0, 1, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(3'b001, flits[ptab[c]], 32'h0, 32'h0, rtab[c]);
      #2;
      checks++; if (out_valid_o !== vtab[c]) begin failures++; $display("FAIL cs_valid cyc=%0d got=%b exp=%b", c, out_valid_o, vtab[c]); end
      checks++; if (in_ready_o[0] !== vtab[c]) begin failures++; $display("FAIL cs_ready cyc=%0d got=%b exp=%b", c, in_ready_o[0], vtab[c]); end
      checks++; if (locked_o !== ltab[c]) begin failures++; $display("FAIL cs_locked cyc=%0d got=%b exp=%b", c, locked_o, ltab[c]); end
      checks++; if (out_data_o !== (vtab[c] ? flits[ptab[c]] : 32'h0)) begin failures++; $display("FAIL cs_data cyc=%0d got=%h", c, out_data_o); end
      checks++; if (int'(dut.r_credit_cnt) != ctab[c]) begin failures++; $display("FAIL cs_credit cyc=%0d got=%0d exp=%0d", c, dut.r_credit_cnt, ctab[c]); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    @(negedge clk); drive(3'b001, 32'h8000_0B00, 32'h0, 32'h0, 1'b0);
    @(negedge clk); drive(3'b001, 32'h8000_0B01, 32'h0, 32'h0, 1'b0);
    @(negedge clk); drive(3'b001, 32'h8000_0B02, 32'h0, 32'h0, 1'b1); #2;
    checks++; if (int'(dut.r_credit_cnt) != 2) begin failures++; $display("FAIL sim_pre_credit got=%0d exp=2", dut.r_credit_cnt); end
    checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL sim_valid got=%b exp=1", out_valid_o); end
    @(negedge clk); drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b1); #2;
    checks++; if (int'(dut.r_credit_cnt) != 2) begin failures++; $display("FAIL sim_both_credit got=%0d exp=2", dut.r_credit_cnt); end
    @(negedge clk); drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b1); #2;
    checks++; if (int'(dut.r_credit_cnt) != 3) begin failures++; $display("FAIL sim_ret1_credit got=%0d exp=3", dut.r_credit_cnt); end
    @(negedge clk); drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b1); #2;
    checks++; if (int'(dut.r_credit_cnt) != 4) begin failures++; $display("FAIL sim_ret2_credit got=%0d exp=4", dut.r_credit_cnt); end
    checks++; if (err_o !== 2'b00) begin failures++; $display("FAIL sim_err_pre got=%b exp=00", err_o); end
    @(negedge clk); drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b0); #2;
    checks++; if (int'(dut.r_credit_cnt) != 4) begin failures++; $display("FAIL sim_sat_credit got=%0d exp=4", dut.r_credit_cnt); end
    checks++; if (err_o !== 2'b10) begin failures++; $display("FAIL sim_overflow_err got=%b exp=10", err_o); end
  endtask

  task automatic test_protocol();
    do_reset();
    @(negedge clk); drive(3'b100, 32'h0, 32'h0, 32'h4000_0022, 1'b0); #2;
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL pe_valid got=%b exp=0", out_valid_o); end
    checks++; if (in_ready_o !== 3'b100) begin failures++; $display("FAIL pe_ready got=%b exp=100", in_ready_o); end
    checks++; if (out_data_o !== 32'h0) begin failures++; $display("FAIL pe_data got=%h exp=0", out_data_o); end
    checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL pe_grant got=%b exp=000", grant_o); end
    @(negedge clk); drive(3'b100, 32'h0, 32'h0, 32'h0000_0023, 1'b0); #2;
    checks++; if (err_o !== 2'b01) begin failures++; $display("FAIL pe_err got=%b exp=01", err_o); end
    checks++; if (int'(dut.r_credit_cnt) != 4) begin failures++; $display("FAIL pe_credit got=%0d exp=4", dut.r_credit_cnt); end
    checks++; if (grant_o !== 3'b100) begin failures++; $display("FAIL pe_head_grant got=%b exp=100", grant_o); end
    checks++; if (out_data_o !== 32'h0000_0023) begin failures++; $display("FAIL pe_head_data got=%h exp=00000023", out_data_o); end
    @(negedge clk); drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b0); #2;
    checks++; if (err_o !== 2'b01) begin failures++; $display("FAIL pe_sticky got=%b exp=01", err_o); end
    checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL pe_locked got=%b exp=1", locked_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clk); drive(3'b001, 32'h0000_0C00, 32'h0, 32'h0, 1'b0); #2;
    checks++; if (err_o !== 2'b10) begin failures++; $display("FAIL rm_err_pre got=%b exp=10", err_o); end
    @(negedge clk); drive(3'b001, 32'h4000_0C01, 32'h0, 32'h0, 1'b0); rst = 1'b1; #2;
    checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL rm_locked_pre got=%b exp=1", locked_o); end
    checks++; if (int'(dut.r_credit_cnt) != 3) begin failures++; $display("FAIL rm_credit_pre got=%0d exp=3", dut.r_credit_cnt); end
    @(negedge clk); rst = 1'b0; drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b0); #2;
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL rm_locked got=%b exp=0", locked_o); end
    checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL rm_grant got=%b exp=000", grant_o); end
    checks++; if (err_o !== 2'b00) begin failures++; $display("FAIL rm_err got=%b exp=00", err_o); end
    checks++; if (int'(dut.r_credit_cnt) != 4) begin failures++; $display("FAIL rm_credit got=%0d exp=4", dut.r_credit_cnt); end
  endtask

  initial begin
    test_reset();
    test_rr_single();
    test_wormhole();
    test_credit_stall();
    test_simultaneous();
    test_protocol();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sw_alloc_rr
